// File: rtl/ddr2_bank_timer_if.sv
// Command and status bundle between a DDR2 command scheduler and the bank timer.
// The scheduler holds the master modport; the timer holds the slave modport.
interface ddr2_bank_timer_if #(
  parameter int NUM_BANKS = 8,
  parameter int ROW_W     = 14
);
  localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  logic                       cmd_valid;
  logic [3:0]                 cmd;
  logic [BW-1:0]              cmd_bank;
  logic [ROW_W-1:0]           cmd_row;
  logic                       cmd_pre_all;

  logic [NUM_BANKS-1:0]       act_ok;
  logic [NUM_BANKS-1:0]       rdwr_ok;
  logic [NUM_BANKS-1:0]       pre_ok;
  logic [NUM_BANKS-1:0]       bank_open;
  logic [NUM_BANKS*ROW_W-1:0] open_row;
  logic                       ref_ok;
  logic                       ref_busy;
  logic                       cmd_err;

  modport master (
    output cmd_valid, cmd, cmd_bank, cmd_row, cmd_pre_all,
    input  act_ok, rdwr_ok, pre_ok, bank_open, open_row, ref_ok, ref_busy, cmd_err
  );

  modport slave (
    input  cmd_valid, cmd, cmd_bank, cmd_row, cmd_pre_all,
    output act_ok, rdwr_ok, pre_ok, bank_open, open_row, ref_ok, ref_busy, cmd_err
  );
endinterface

// File: rtl/ddr2_bank_timer.sv
// DDR2 per-bank and rank-level timing tracker: holds open-row state and down-counters,
// and reports which commands are legal in the current cycle.
module ddr2_bank_timer #(
  parameter int NUM_BANKS = 8,
  parameter int ROW_W     = 14,
  parameter int TRCD      = 15,
  parameter int TRP       = 15,
  parameter int TRAS      = 40,
  parameter int TRC       = 55,
  parameter int TRRD      = 10,
  parameter int TWR       = 15,
  parameter int TRTP      = 7,
  parameter int TFAW      = 45,
  parameter int TRFC      = 51
) (
  input  logic             clk,
  input  logic             rst,
  ddr2_bank_timer_if.slave bus
);
  localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  localparam logic [3:0] CMD_MRS = 4'b0000;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_NOP = 4'b0111;

  typedef logic [7:0] cnt_t;

  // Counters hold the cycles still to wait after the current one, so a load of
  // N-1 at the issuing edge reaches zero exactly N cycles after the command.
  localparam cnt_t L_RCD = cnt_t'(TRCD - 1);
  localparam cnt_t L_RP  = cnt_t'(TRP - 1);
  localparam cnt_t L_RAS = cnt_t'(TRAS - 1);
  localparam cnt_t L_RC  = cnt_t'(TRC - 1);
  localparam cnt_t L_RRD = cnt_t'(TRRD - 1);
  localparam cnt_t L_WR  = cnt_t'(TWR - 1);
  localparam cnt_t L_RTP = cnt_t'(TRTP - 1);
  localparam cnt_t L_FAW = cnt_t'(TFAW - 1);
  localparam cnt_t L_RFC = cnt_t'(TRFC - 1);

  function automatic cnt_t dec(cnt_t c);
    return (c == 8'd0) ? 8'd0 : c - 8'd1;
  endfunction

  function automatic cnt_t cmax(cnt_t a, cnt_t b);
    return (a > b) ? a : b;
  endfunction

  logic [NUM_BANKS-1:0]            r_open;
  logic [NUM_BANKS-1:0][ROW_W-1:0] r_row;
  logic [NUM_BANKS-1:0][7:0]       r_rcd;
  logic [NUM_BANKS-1:0][7:0]       r_ras;
  logic [NUM_BANKS-1:0][7:0]       r_rc;
  logic [NUM_BANKS-1:0][7:0]       r_rp;
  logic [NUM_BANKS-1:0][7:0]       r_wpre;
  logic [3:0][7:0]                 r_faw;
  cnt_t                            r_rrd;
  cnt_t                            r_rfc;
  logic                            r_err;

  logic [NUM_BANKS-1:0] w_hit;
  logic [NUM_BANKS-1:0] w_act_ok;
  logic [NUM_BANKS-1:0] w_rdwr_ok;
  logic [NUM_BANKS-1:0] w_pre_ok;
  logic [3:0]           w_faw_sel;
  logic                 w_faw_free;
  logic                 w_ref_busy;
  logic                 w_ref_ok;
  logic                 w_act_go;
  logic                 w_rd_go;
  logic                 w_wr_go;
  logic                 w_pre_go;
  logic                 w_ref_go;
  logic                 w_err;

  assign w_ref_busy = (r_rfc != 8'd0);

  // Lowest-index idle tFAW slot takes the next activate.
  always_comb begin
    w_faw_free = 1'b0;
    w_faw_sel  = '0;
    for (int i = 0; i < 4; i++) begin
      if (r_faw[i] == 8'd0 && !w_faw_free) begin
        w_faw_sel[i] = 1'b1;
        w_faw_free   = 1'b1;
      end
    end
  end

  always_comb begin
    w_ref_ok = !w_ref_busy && (r_open == '0);
    for (int b = 0; b < NUM_BANKS; b++) begin
      // An out-of-range bank index matches no bank and is therefore never legal.
      w_hit[b]     = (bus.cmd_bank == BW'(b));
      w_act_ok[b]  = !r_open[b] && (r_rc[b] == 8'd0) && (r_rp[b] == 8'd0) &&
                     (r_rrd == 8'd0) && w_faw_free && !w_ref_busy;
      w_rdwr_ok[b] = r_open[b] && (r_rcd[b] == 8'd0) && !w_ref_busy;
      w_pre_ok[b]  = !w_ref_busy &&
                     (!r_open[b] || ((r_ras[b] == 8'd0) && (r_wpre[b] == 8'd0)));
      if (r_rp[b] != 8'd0 || r_rc[b] != 8'd0) w_ref_ok = 1'b0;
    end
  end

  always_comb begin
    w_act_go = 1'b0;
    w_rd_go  = 1'b0;
    w_wr_go  = 1'b0;
    w_pre_go = 1'b0;
    w_ref_go = 1'b0;
    w_err    = 1'b0;
    if (bus.cmd_valid) begin
      case (bus.cmd)
        CMD_ACT: w_act_go = |(w_hit & w_act_ok);
        CMD_RD:  w_rd_go  = |(w_hit & w_rdwr_ok);
        CMD_WR:  w_wr_go  = |(w_hit & w_rdwr_ok);
        CMD_PRE: w_pre_go = bus.cmd_pre_all ? (&w_pre_ok) : (|(w_hit & w_pre_ok));
        CMD_REF: w_ref_go = w_ref_ok;
        default: ;
      endcase
      w_err = !(w_act_go || w_rd_go || w_wr_go || w_pre_go || w_ref_go ||
                bus.cmd == CMD_NOP || bus.cmd == CMD_MRS);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_open <= '0;
      r_row  <= '0;
      r_rcd  <= '0;
      r_ras  <= '0;
      r_rc   <= '0;
      r_rp   <= '0;
      r_wpre <= '0;
      r_faw  <= '0;
      r_rrd  <= '0;
      r_rfc  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_rrd <= w_act_go ? L_RRD : dec(r_rrd);
      r_rfc <= w_ref_go ? L_RFC : dec(r_rfc);
      for (int i = 0; i < 4; i++) begin
        r_faw[i] <= (w_act_go && w_faw_sel[i]) ? L_FAW : dec(r_faw[i]);
      end
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (w_act_go && w_hit[b]) begin
          r_open[b] <= 1'b1;
          r_row[b]  <= bus.cmd_row;
          r_rcd[b]  <= L_RCD;
          r_ras[b]  <= L_RAS;
          r_rc[b]   <= L_RC;
        end else begin
          r_rcd[b]  <= dec(r_rcd[b]);
          r_ras[b]  <= dec(r_ras[b]);
          r_rc[b]   <= dec(r_rc[b]);
        end
        if ((w_rd_go || w_wr_go) && w_hit[b]) begin
          r_wpre[b] <= cmax(dec(r_wpre[b]), w_wr_go ? L_WR : L_RTP);
        end else begin
          r_wpre[b] <= dec(r_wpre[b]);
        end
        if (w_pre_go && (bus.cmd_pre_all || w_hit[b]) && r_open[b]) begin
          r_open[b] <= 1'b0;
          r_rp[b]   <= L_RP;
        end else begin
          r_rp[b]   <= dec(r_rp[b]);
        end
      end
      r_err <= w_err;
    end
  end

  assign bus.act_ok    = w_act_ok;
  assign bus.rdwr_ok   = w_rdwr_ok;
  assign bus.pre_ok    = w_pre_ok;
  assign bus.bank_open = r_open;
  assign bus.open_row  = r_row;
  assign bus.ref_ok    = w_ref_ok;
  assign bus.ref_busy  = w_ref_busy;
  assign bus.cmd_err   = r_err;

endmodule

// File: tb/tb_ddr2_bank_timer.sv
// Bench for ddr2_bank_timer: directed vector table, timing corner sequences and random
// commands, all compared each cycle against an absolute-time reference model.
module tb_ddr2_bank_timer;
  localparam int NB = 8;
  localparam int RW = 14;
  localparam int BW = 3;
  localparam int TRCD = 15, TRP = 15, TRAS = 40, TRC = 55, TRRD = 10;
  localparam int TWR = 15, TRTP = 7, TFAW = 45, TRFC = 51;

  localparam logic [3:0] MRS = 4'b0000, REF = 4'b0001, PRE = 4'b0010, ACT = 4'b0011;
  localparam logic [3:0] WR = 4'b0100, RD = 4'b0101, NOP = 4'b0111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ddr2_bank_timer_if #(.NUM_BANKS(NB), .ROW_W(RW)) bus ();

  ddr2_bank_timer #(
    .NUM_BANKS(NB), .ROW_W(RW), .TRCD(TRCD), .TRP(TRP), .TRAS(TRAS), .TRC(TRC),
    .TRRD(TRRD), .TWR(TWR), .TRTP(TRTP), .TFAW(TFAW), .TRFC(TRFC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: each timing rule is the earliest absolute cycle a command may go.
  int               t;
  bit               m_open [NB];
  logic [RW-1:0]    m_row  [NB];
  int               rcd_u [NB], ras_u [NB], rc_u [NB], rp_u [NB], wpre_u [NB];
  int               rrd_u, rfc_u;
  int               act_q [$];
  bit               m_err;

  task automatic check(string nm, logic [127:0] a, logic [127:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s at t=%0d: got %0h, want %0h", nm, t, a, e);
    end
  endtask

  task automatic model_reset();
    t = 0;
    for (int b = 0; b < NB; b++) begin
      m_open[b] = 0; m_row[b] = '0;
      rcd_u[b] = 0; ras_u[b] = 0; rc_u[b] = 0; rp_u[b] = 0; wpre_u[b] = 0;
    end
    rrd_u = 0; rfc_u = 0; m_err = 0;
    act_q.delete();
  endtask

  function automatic bit m_busy();
    return t < rfc_u;
  endfunction

  // No more than four activates inside any rolling tFAW window.
  function automatic bit m_faw_free();
    int n;
    n = 0;
    foreach (act_q[i]) if (act_q[i] + TFAW > t) n++;
    return n < 4;
  endfunction

  function automatic bit m_act_ok(int b);
    return !m_open[b] && t >= rc_u[b] && t >= rp_u[b] && t >= rrd_u && m_faw_free() && !m_busy();
  endfunction

  function automatic bit m_rdwr_ok(int b);
    return m_open[b] && t >= rcd_u[b] && !m_busy();
  endfunction

  function automatic bit m_pre_ok(int b);
    return !m_busy() && (!m_open[b] || (t >= ras_u[b] && t >= wpre_u[b]));
  endfunction

  function automatic bit m_ref_ok();
    if (m_busy()) return 0;
    for (int b = 0; b < NB; b++)
      if (m_open[b] || t < rp_u[b] || t < rc_u[b]) return 0;
    return 1;
  endfunction

  task automatic apply(bit v, logic [3:0] c, int b, logic [RW-1:0] r, bit pa);
    bit ok;
    int lim;
    ok = 1;
    if (v) begin
      case (c)
        NOP, MRS: ok = 1;
        ACT: begin
          ok = (b < NB) && m_act_ok(b);
          if (ok) begin
            m_open[b] = 1; m_row[b] = r;
            rcd_u[b] = t + TRCD; ras_u[b] = t + TRAS; rc_u[b] = t + TRC;
            rrd_u = t + TRRD;
            act_q.push_back(t);
          end
        end
        RD, WR: begin
          ok = (b < NB) && m_rdwr_ok(b);
          if (ok) begin
            lim = t + ((c == WR) ? TWR : TRTP);
            if (lim > wpre_u[b]) wpre_u[b] = lim;
          end
        end
        PRE: begin
          if (pa) begin
            for (int i = 0; i < NB; i++) if (!m_pre_ok(i)) ok = 0;
            if (ok)
              for (int i = 0; i < NB; i++)
                if (m_open[i]) begin m_open[i] = 0; rp_u[i] = t + TRP; end
          end else begin
            ok = (b < NB) && m_pre_ok(b);
            if (ok && m_open[b]) begin m_open[b] = 0; rp_u[b] = t + TRP; end
          end
        end
        REF: begin
          ok = m_ref_ok();
          if (ok) rfc_u = t + TRFC;
        end
        default: ok = 0;
      endcase
    end
    m_err = !ok;
    while (act_q.size() > 0 && act_q[0] + TFAW <= t) void'(act_q.pop_front());
  endtask

  task automatic cmp_all();
    logic [NB-1:0]    ea, er, ep, eo;
    logic [NB*RW-1:0] erow;
    for (int b = 0; b < NB; b++) begin
      ea[b] = m_act_ok(b); er[b] = m_rdwr_ok(b); ep[b] = m_pre_ok(b); eo[b] = m_open[b];
      erow[b*RW +: RW] = m_row[b];
    end
    check("act_ok",    128'(bus.act_ok),    128'(ea));
    check("rdwr_ok",   128'(bus.rdwr_ok),   128'(er));
    check("pre_ok",    128'(bus.pre_ok),    128'(ep));
    check("bank_open", 128'(bus.bank_open), 128'(eo));
    check("open_row",  128'(bus.open_row),  128'(erow));
    check("ref_ok",    128'(bus.ref_ok),    128'(m_ref_ok()));
    check("ref_busy",  128'(bus.ref_busy),  128'(m_busy()));
    check("cmd_err",   128'(bus.cmd_err),   128'(m_err));
  endtask

  // Called just after a falling edge: compare, drive, advance the model, wait for the edge.
  task automatic issue(bit v, logic [3:0] c, int b, logic [RW-1:0] r, bit pa);
    cmp_all();
    bus.cmd_valid = v; bus.cmd = c; bus.cmd_bank = BW'(b); bus.cmd_row = r; bus.cmd_pre_all = pa;
    apply(v, c, b, r, pa);
    @(posedge clk);
    t++;
  endtask

  task automatic chk_reset_vals(string tag);
    check({tag, "_act_ok"},    128'(bus.act_ok),    128'({NB{1'b1}}));
    check({tag, "_rdwr_ok"},   128'(bus.rdwr_ok),   128'(0));
    check({tag, "_pre_ok"},    128'(bus.pre_ok),    128'({NB{1'b1}}));
    check({tag, "_bank_open"}, 128'(bus.bank_open), 128'(0));
    check({tag, "_open_row"},  128'(bus.open_row),  128'(0));
    check({tag, "_ref_ok"},    128'(bus.ref_ok),    128'(1));
    check({tag, "_ref_busy"},  128'(bus.ref_busy),  128'(0));
    check({tag, "_cmd_err"},   128'(bus.cmd_err),   128'(0));
  endtask

  // Returns just after a rising edge; the following cycle is model cycle 0.
  task automatic rst_pulse();
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk_reset_vals("rst_async");
    @(posedge clk);
    @(negedge clk);
    chk_reset_vals("rst_hold");
    rst = 1'b0;
    model_reset();
    @(posedge clk);
  endtask

  typedef struct {
    int            idle;
    logic [3:0]    cmd;
    int            bank;
    logic [RW-1:0] row;
    bit            pa;
    bit            exp_err;
    bit            exp_open;
  } vec_t;

  vec_t tbl [16];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel;
    logic [3:0] c;

    bus.cmd_valid = 1'b0; bus.cmd = NOP; bus.cmd_bank = '0; bus.cmd_row = '0; bus.cmd_pre_all = 1'b0;
    model_reset();

    tbl[0]  = '{0,  ACT,     1, 14'h00AA, 0, 0, 1};
    tbl[1]  = '{0,  RD,      1, 14'h0,    0, 1, 1};
    tbl[2]  = '{11, RD,      1, 14'h0,    0, 0, 1};
    tbl[3]  = '{0,  PRE,     1, 14'h0,    0, 1, 1};
    tbl[4]  = '{21, PRE,     1, 14'h0,    0, 0, 0};
    tbl[5]  = '{0,  ACT,     1, 14'h0BB,  0, 1, 0};
    tbl[6]  = '{11, ACT,     1, 14'h0CC,  0, 0, 1};
    tbl[7]  = '{0,  4'b1000, 0, 14'h0,    0, 1, 0};
    tbl[8]  = '{0,  NOP,     0, 14'h0,    0, 0, 0};
    tbl[9]  = '{0,  MRS,     3, 14'h0,    0, 0, 0};
    tbl[10] = '{0,  REF,     1, 14'h0,    0, 1, 1};
    tbl[11] = '{0,  PRE,     1, 14'h0,    1, 1, 1};
    tbl[12] = '{28, PRE,     1, 14'h0,    1, 0, 0};
    tbl[13] = '{0,  REF,     1, 14'h0,    0, 1, 0};
    tbl[14] = '{11, REF,     1, 14'h0,    0, 0, 0};
    tbl[15] = '{0,  ACT,     2, 14'h0DD,  0, 1, 0};

    rst_pulse();
    foreach (tbl[i]) begin
      repeat (tbl[i].idle) begin @(negedge clk); issue(0, NOP, 0, '0, 0); end
      @(negedge clk);
      issue(1, tbl[i].cmd, tbl[i].bank, tbl[i].row, tbl[i].pa);
      @(negedge clk);
      check($sformatf("tbl%0d_err", i), 128'(bus.cmd_err), 128'(tbl[i].exp_err));
      check($sformatf("tbl%0d_open", i), 128'(bus.bank_open[tbl[i].bank]), 128'(tbl[i].exp_open));
      issue(0, NOP, 0, '0, 0);
    end

    // Activate to read/write delay and row latch.
    rst_pulse();
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      if (k >= 1) begin
        check("s35_open", 128'(bus.bank_open[2]), 128'(1));
        check("s35_row", 128'(bus.open_row[2*RW +: RW]), 128'(14'h1234));
      end
      if (k >= 1 && k <= 14) check("s35_rcd_block", 128'(bus.rdwr_ok[2]), 128'(0));
      if (k == 15) check("s35_rcd_free", 128'(bus.rdwr_ok[2]), 128'(1));
      issue(k == 0, ACT, 2, 14'h1234, 0);
    end

    // Activate-to-activate, early precharge and row cycle.
    rst_pulse();
    for (int k = 0; k <= 56; k++) begin
      @(negedge clk);
      if (k >= 1 && k <= 9) check("s36_rrd_block", 128'(bus.act_ok[1]), 128'(0));
      if (k == 10) check("s36_rrd_free", 128'(bus.act_ok[1]), 128'(1));
      if (k == 21) begin
        check("s36_pre_err", 128'(bus.cmd_err), 128'(1));
        check("s36_still_open", 128'(bus.bank_open[0]), 128'(1));
      end
      if (k == 41) check("s36_closed", 128'(bus.bank_open[0]), 128'(0));
      if (k == 54) check("s36_rc_block", 128'(bus.act_ok[0]), 128'(0));
      if (k == 55) check("s36_rc_free", 128'(bus.act_ok[0]), 128'(1));
      if (k == 0) issue(1, ACT, 0, 14'h0011, 0);
      else if (k == 20 || k == 40) issue(1, PRE, 0, '0, 0);
      else issue(0, NOP, 0, '0, 0);
    end

    // Four-activate window.
    rst_pulse();
    for (int k = 0; k <= 46; k++) begin
      @(negedge clk);
      if (k == 40 || k == 44) check("s37_faw_block", 128'(bus.act_ok[4]), 128'(0));
      if (k == 41) begin
        check("s37_act_err", 128'(bus.cmd_err), 128'(1));
        check("s37_b4_closed", 128'(bus.bank_open[4]), 128'(0));
      end
      if (k == 45) check("s37_faw_free", 128'(bus.act_ok[4]), 128'(1));
      if (k % 10 == 0 && k <= 40) issue(1, ACT, k / 10, RW'(k), 0);
      else issue(0, NOP, 0, '0, 0);
    end

    // Write recovery before precharge.
    rst_pulse();
    for (int k = 0; k <= 45; k++) begin
      @(negedge clk);
      if (k == 44) check("s38_wr_block", 128'(bus.pre_ok[0]), 128'(0));
      if (k == 45) check("s38_wr_free", 128'(bus.pre_ok[0]), 128'(1));
      if (k == 0) issue(1, ACT, 0, 14'h0022, 0);
      else if (k == 30) issue(1, WR, 0, '0, 0);
      else issue(0, NOP, 0, '0, 0);
    end

    // Read-to-precharge extends past tRAS.
    rst_pulse();
    for (int k = 0; k <= 51; k++) begin
      @(negedge clk);
      if (k == 50) check("s38_rtp_block", 128'(bus.pre_ok[0]), 128'(0));
      if (k == 51) check("s38_rtp_free", 128'(bus.pre_ok[0]), 128'(1));
      if (k == 0) issue(1, ACT, 0, 14'h0033, 0);
      else if (k == 44) issue(1, RD, 0, '0, 0);
      else issue(0, NOP, 0, '0, 0);
    end

    // Refresh busy window.
    rst_pulse();
    for (int k = 0; k <= 51; k++) begin
      @(negedge clk);
      if (k >= 1 && k <= 50) begin
        check("s39_busy", 128'(bus.ref_busy), 128'(1));
        check("s39_act_block", 128'(bus.act_ok), 128'(0));
      end
      if (k == 11) check("s39_act_err", 128'(bus.cmd_err), 128'(1));
      if (k == 51) begin
        check("s39_idle", 128'(bus.ref_busy), 128'(0));
        check("s39_act_free", 128'(bus.act_ok), 128'({NB{1'b1}}));
      end
      if (k == 0) issue(1, REF, 0, '0, 0);
      else if (k == 10) issue(1, ACT, 0, 14'h0044, 0);
      else issue(0, NOP, 0, '0, 0);
    end

    // Reset in the middle of running windows.
    rst_pulse();
    for (int k = 0; k <= 25; k++) begin
      @(negedge clk);
      if (k == 0 || k == 10) issue(1, ACT, k / 10, RW'(k + 5), 0);
      else if (k == 20) issue(1, WR, 0, '0, 0);
      else issue(0, NOP, 0, '0, 0);
    end
    rst_pulse();
    @(negedge clk);
    issue(1, ACT, 5, 14'h0555, 0);
    @(negedge clk);
    check("s40_act_accept", 128'(bus.bank_open[5]), 128'(1));
    check("s40_no_err", 128'(bus.cmd_err), 128'(0));
    issue(0, NOP, 0, '0, 0);

    // Random traffic with occasional mid-run resets.
    rst_pulse();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        rst_pulse();
      end else begin
        sel = int'($urandom_range(0, 15));
        if (sel <= 4) c = ACT;
        else if (sel <= 6) c = RD;
        else if (sel <= 8) c = WR;
        else if (sel <= 11) c = PRE;
        else if (sel == 12) c = REF;
        else if (sel == 13) c = NOP;
        else if (sel == 14) c = MRS;
        else c = ($urandom_range(0, 1) == 0) ? 4'b0110 : 4'($urandom_range(8, 15));
        @(negedge clk);
        issue($urandom_range(0, 3) != 0, c, int'($urandom_range(0, NB - 1)),
              RW'($urandom), $urandom_range(0, 5) == 0);
      end
    end
    @(negedge clk);
    cmp_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr2_bank_timer.md
DDR2_BANK_TIMER -- requirements
Module: ddr2_bank_timer

Interface
REQ-001 Parameter NUM_BANKS, 8, number of tracked banks (2..16).
REQ-002 Parameter ROW_W, 14, row address width.
REQ-003 Parameters TRCD 15, TRP 15, TRAS 40, TRC 55, TRRD 10, TWR 15, TRTP 7, TFAW 45, TRFC 51; clock cycles, each 1..255.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 cmd_valid  in  1  command issued this cycle; at most one command per cycle.
REQ-007 cmd  in  4  encoding: ACT 0011, RD 0101, WR 0100, PRE 0010, REF 0001, NOP 0111, MRS 0000.
REQ-008 cmd_bank  in  clog2(NUM_BANKS)  target bank.
REQ-009 cmd_row  in  ROW_W  row for ACT; ignored otherwise.
REQ-010 cmd_pre_all  in  1  with PRE: precharge all banks.
REQ-011 act_ok, rdwr_ok, pre_ok  out  NUM_BANKS each  per-bank legality of ACT, RD/WR, PRE this cycle.
REQ-012 bank_open  out  NUM_BANKS  bank holds an open row.
REQ-013 open_row  out  NUM_BANKS*ROW_W  open row per bank, bank b at bits [b*ROW_W +: ROW_W].
REQ-014 ref_ok  out  1  REF legal this cycle; ref_busy  out  1  tRFC in progress.
REQ-015 cmd_err  out  1  registered one-cycle pulse: previous-cycle command was illegal.

Function
REQ-016 Legality outputs SHALL be combinational from internal counters/state; command acceptance is evaluated against them in the same cycle.
REQ-017 Per bank SHALL be kept: open flag, open row, down-counters rcd, ras, rc, rp, wpre (write/read-to-precharge); each counter saturates at 0.
REQ-018 Globally SHALL be kept: rrd counter, rfc counter, four tFAW window counters.
REQ-019 A counter loaded with value N in cycle T SHALL read zero from cycle T+N, so the gated command is first legal exactly N cycles after the cycle the causing command was issued.
REQ-020 act_ok[b] = !bank_open[b] & rc==0 & rp==0 & rrd==0 & any tFAW counter==0 & !ref_busy.
REQ-021 rdwr_ok[b] = bank_open[b] & rcd==0 & !ref_busy.
REQ-022 pre_ok[b] = !ref_busy & (!bank_open[b] | (ras==0 & wpre==0)); PRE to an idle bank is a legal no-op.
REQ-023 ref_ok = no bank open & all rp==0 & all rc==0 & !ref_busy.
REQ-024 Legal ACT: set open, latch cmd_row, load rcd=TRCD, ras=TRAS, rc=TRC, rrd=TRRD, and load TFAW into the lowest-index tFAW counter that is zero.
REQ-025 Legal WR: wpre = max(wpre, TWR); legal RD: wpre = max(wpre, TRTP).
REQ-026 Legal PRE (single): if bank open, clear open, load rp=TRP; PRE with cmd_pre_all is legal only when pre_ok is set for every bank and closes every open bank, loading rp on each.
REQ-027 Legal REF: load rfc=TRFC; ref_busy = rfc!=0.
REQ-028 NOP and MRS SHALL never set cmd_err and change no state (MRS legality is the initialiser's responsibility).
REQ-029 Illegal command (gating output low, or unknown encoding): no state change, cmd_err=1 next cycle.
REQ-030 cmd_valid=0: counters decrement only; cmd_err=0 next cycle.
REQ-031 Counters SHALL decrement in the same cycle a different counter is loaded; a counter being loaded takes the load value, not load-1.
REQ-032 Out-of-range cmd_bank (>= NUM_BANKS) SHALL be illegal.

Reset
REQ-033 While rst high: all counters 0, bank_open 0, open_row 0, cmd_err 0, ref_busy 0; hence act_ok all 1, rdwr_ok 0, pre_ok all 1, ref_ok 1.
REQ-034 Reset asserted mid-operation SHALL abandon all timing windows immediately; no command is evaluated while rst high.

Verification
REQ-035 ACT bank2 row 0x1234 at cycle 0 -> bank_open[2]=1, open_row[2]=0x1234 from cycle 1; rdwr_ok[2] low cycles 1..14, high at 15.
REQ-036 ACT bank0 at 0 -> act_ok[1] low cycles 1..9, high at 10; PRE bank0 at 20 -> cmd_err=1 at 21, bank still open; PRE at 40 accepted, act_ok[0] high at 55.
REQ-037 ACT banks 0,1,2,3 at cycles 0,10,20,30 -> act_ok[4] low at 40, high at 45; ACT bank4 at 40 -> cmd_err at 41.
REQ-038 ACT b0 at 0, WR b0 at 30 -> pre_ok[0] low until 45, high at 45; RD at 44 instead -> pre_ok[0] high at 51.
REQ-039 All idle, REF at 0 -> ref_busy 1 cycles 1..50, all act_ok 0 in that span; ACT at 10 -> cmd_err at 11; act_ok all 1 at 51.
REQ-040 Banks open with counters running, rst pulsed 1 cycle -> next cycle all outputs equal REQ-033 values; ACT immediately accepted.
